// File: rtl/mem_seq_if.sv
// Request, result and byte-bus signals shared by mem_seq and its requester/memory side.
interface mem_seq_if #(
   parameter int MAXB  = 4,
   parameter int OFFW  = 16,
   parameter int ADDRW = 20
);
   logic               req;
   logic [1:0]         op;
   logic [3:0]         len;
   logic [15:0]        seg;
   logic [OFFW-1:0]    off;
   logic [OFFW-1:0]    sp;
   logic [8*MAXB-1:0]  wdata;
   logic [8*MAXB-1:0]  rdata;
   logic [OFFW-1:0]    sp_out;
   logic               sp_we;
   logic               busy;
   logic               done;
   logic               err;
   logic [ADDRW-1:0]   address;
   logic [7:0]         bus;
   logic [7:0]         data;
   logic               wreq;

   modport master (
      output req, op, len, seg, off, sp, wdata, bus,
      input  rdata, sp_out, sp_we, busy, done, err, address, data, wreq
   );

   modport slave (
      input  req, op, len, seg, off, sp, wdata, bus,
      output rdata, sp_out, sp_we, busy, done, err, address, data, wreq
   );
endinterface

// File: rtl/mem_seq.sv
// Segmented byte-serial memory sequencer: READ/WRITE/PUSH/POP of up to MAXB bytes,
// one byte per cycle, with real-mode style segment:offset address generation.
module mem_seq #(
   parameter int MAXB  = 4,
   parameter int OFFW  = 16,
   parameter int ADDRW = 20
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     locked,
   mem_seq_if.slave mif
);
   localparam int         BW     = 8 * MAXB;
   localparam int         WMAX   = (OFFW > ADDRW) ? OFFW : ADDRW;
   localparam int         SUMW   = (WMAX > 20) ? WMAX : 20;
   localparam logic [3:0] MAXB_L = 4'(MAXB);
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

   state_t           r_state;
   logic [1:0]       r_op;
   logic [3:0]       r_len;
   logic [3:0]       r_idx;
   logic [15:0]      r_seg;
   logic [OFFW-1:0]  r_base;
   logic [OFFW-1:0]  r_off;
   logic [OFFW-1:0]  r_sp_out;
   logic [BW-1:0]    r_wdata;
   logic [BW-1:0]    r_rdata;
   logic             r_done;
   logic             r_err;
   logic             r_sp_we;
   logic             r_wreq;
   logic [ADDRW-1:0] r_address;
   logic [7:0]       r_data;

   logic [OFFW-1:0]  w_base;
   logic [OFFW-1:0]  w_next_off;
   logic [BW-1:0]    w_wshift;
   logic             w_len_bad;
   logic             w_last;
   logic             w_req_wr;
   logic             w_cur_wr;

   // Segment carries are confined to the physical sum; the offset itself wraps at OFFW bits.
   function automatic logic [ADDRW-1:0] phys(input logic [15:0] s, input logic [OFFW-1:0] o);
      logic [SUMW-1:0] sum;
      sum = SUMW'({s, 4'h0}) + SUMW'(o);
      return sum[ADDRW-1:0];
   endfunction

   always_comb begin
      w_base = mif.off;
      case (mif.op)
         OP_PUSH: w_base = mif.sp - OFFW'(mif.len);
         OP_POP:  w_base = mif.sp;
         default: w_base = mif.off;
      endcase
   end

   assign w_len_bad  = (mif.len == 4'd0) || (mif.len > MAXB_L);
   assign w_last     = (r_idx == r_len - 4'd1);
   assign w_next_off = r_off + OFFW'(1);
   assign w_wshift   = r_wdata >> 8;
   assign w_req_wr   = (mif.op == OP_WRITE) || (mif.op == OP_PUSH);
   assign w_cur_wr   = (r_op == OP_WRITE) || (r_op == OP_PUSH);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= 4'd0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_sp_we   <= 1'b0;
         r_wreq    <= 1'b0;
         r_rdata   <= '0;
         r_sp_out  <= '0;
         r_data    <= 8'h00;
         r_address <= '0;
      end else if (locked) begin
         case (r_state)
            S_IDLE: begin
               r_done    <= 1'b0;
               r_err     <= 1'b0;
               r_sp_we   <= 1'b0;
               r_wreq    <= 1'b0;
               r_address <= '0;
               if (mif.req) begin
                  r_op    <= mif.op;
                  r_len   <= mif.len;
                  r_seg   <= mif.seg;
                  r_wdata <= mif.wdata;
                  r_base  <= w_base;
                  r_off   <= w_base;
                  r_idx   <= 4'd0;
                  r_rdata <= '0;
                  if (w_len_bad) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state   <= S_XFER;
                     r_address <= phys(mif.seg, w_base);
                     r_wreq    <= w_req_wr;
                     r_data    <= mif.wdata[7:0];
                  end
               end
            end
            S_XFER: begin
               if (!w_cur_wr)
                  r_rdata[8*r_idx +: 8] <= mif.bus;
               if (w_last) begin
                  r_state   <= S_FIN;
                  r_address <= '0;
                  r_wreq    <= 1'b0;
                  r_data    <= 8'h00;
                  r_done    <= 1'b1;
                  r_err     <= 1'b0;
                  if (r_op == OP_PUSH) begin
                     r_sp_we  <= 1'b1;
                     r_sp_out <= r_base;
                  end else if (r_op == OP_POP) begin
                     r_sp_we  <= 1'b1;
                     r_sp_out <= r_base + OFFW'(r_len);
                  end
               end else begin
                  r_idx     <= r_idx + 4'd1;
                  r_off     <= w_next_off;
                  r_address <= phys(r_seg, w_next_off);
                  r_wdata   <= w_wshift;
                  r_data    <= w_wshift[7:0];
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_sp_we <= 1'b0;
            end
         endcase
      end
   end

   assign mif.rdata   = r_rdata;
   assign mif.sp_out  = r_sp_out;
   assign mif.sp_we   = r_sp_we;
   assign mif.busy    = (r_state != S_IDLE);
   assign mif.done    = r_done;
   assign mif.err     = r_err;
   assign mif.address = r_address;
   assign mif.data    = r_data;
   assign mif.wreq    = r_wreq;
endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: directed vector table, hand-written stall/reset/busy sequences,
// and random transactions checked against a byte-addressed memory model.
module tb_mem_seq;
   localparam int MAXB  = 4;
   localparam int OFFW  = 16;
   localparam int ADDRW = 20;

   logic clock = 1'b0;
   logic reset;
   logic locked;

   always #5 clock = ~clock;

   mem_seq_if #(.MAXB(MAXB), .OFFW(OFFW), .ADDRW(ADDRW)) mif ();

   mem_seq #(.MAXB(MAXB), .OFFW(OFFW), .ADDRW(ADDRW)) dut (
      .clock  (clock),
      .reset  (reset),
      .locked (locked),
      .mif    (mif)
   );

   // Memory seen by the DUT: untouched bytes come from a fixed fill pattern.
   logic [7:0] mem      [0:(1<<ADDRW)-1];
   bit         wr_valid [0:(1<<ADDRW)-1];

   function automatic logic [7:0] init_byte(input logic [19:0] a);
      if (a == 20'hF0010) return 8'h34;
      if (a == 20'hF0011) return 8'h12;
      return a[7:0] ^ a[19:12] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] mem_rd(input logic [19:0] a);
      return wr_valid[a] ? mem[a] : init_byte(a);
   endfunction

   assign mif.bus = mem_rd(mif.address);

   always @(posedge clock) begin
      if (locked && mif.wreq) begin
         mem[mif.address]      <= mif.data;
         wr_valid[mif.address] <= 1'b1;
      end
   end

   // Reference memory: what memory should contain after each completed transfer.
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] ref_rd(input logic [19:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
   endfunction

   function automatic logic [19:0] m_addr(input logic [15:0] s, input int unsigned offs);
      int unsigned t;
      t = (32'(s) * 16 + (offs % 65536)) % 1048576;
      return t[19:0];
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [3:0] len, input logic [15:0] seg,
                          input logic [15:0] off, input logic [15:0] sp, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [15:0] spo, output logic e);
      logic [19:0] qa[$];
      logic        qw[$];
      logic [7:0]  qd[$];
      int          done_edge;
      int          nb;
      bit          bad, wr;
      int unsigned base;
      logic [31:0] exp_rd;
      logic [19:0] a;
      bad = (len == 0) || (len > MAXB);
      wr  = (op == 2'b01) || (op == 2'b10);
      nb  = bad ? 0 : int'(len);
      case (op)
         2'b10:   base = (32'(sp) + 65536 - 32'(len)) % 65536;
         2'b11:   base = 32'(sp);
         default: base = 32'(off);
      endcase
      @(negedge clock);
      mif.req = 1'b1; mif.op = op; mif.len = len; mif.seg = seg;
      mif.off = off; mif.sp = sp; mif.wdata = wd;
      @(posedge clock);
      done_edge = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 1) mif.req = 1'b0;
         if (mif.done) begin
            done_edge = k;
            break;
         end
         qa.push_back(mif.address);
         qw.push_back(mif.wreq);
         qd.push_back(mif.data);
      end
      rd  = mif.rdata;
      spo = mif.sp_out;
      e   = mif.err;
      chk("latency", 64'(done_edge), 64'(bad ? 1 : int'(len) + 1));
      chk("fin_address", 64'(mif.address), 64'd0);
      chk("fin_wreq", 64'(mif.wreq), 64'd0);
      chk("err", 64'(mif.err), 64'(bad));
      chk("xfer_cycles", 64'(qa.size()), 64'(nb));
      exp_rd = 32'h0;
      for (int i = 0; i < nb; i++) begin
         a = m_addr(seg, base + i);
         if (i < qa.size()) begin
            chk("xfer_address", 64'(qa[i]), 64'(a));
            chk("xfer_wreq", 64'(qw[i]), 64'(wr));
            if (wr) chk("xfer_data", 64'(qd[i]), 64'(wd[8*i +: 8]));
         end
         if (wr) ref_mem[int'(a)] = wd[8*i +: 8];
         else    exp_rd[8*i +: 8] = ref_rd(a);
      end
      chk("rdata", 64'(mif.rdata), 64'(exp_rd));
      chk("sp_we", 64'(mif.sp_we), 64'(!bad && op[1]));
      if (!bad && op[1])
         chk("sp_out", 64'(mif.sp_out),
             64'(op == 2'b10 ? base : (32'(sp) + 32'(len)) % 65536));
      @(negedge clock);
      chk("done_drop", 64'(mif.done), 64'd0);
      chk("idle_busy", 64'(mif.busy), 64'd0);
      if (wr)
         for (int i = 0; i < nb; i++) begin
            a = m_addr(seg, base + i);
            chk("mem_written", 64'(mem_rd(a)), 64'(ref_rd(a)));
         end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  len;
      logic [15:0] seg;
      logic [15:0] off;
      logic [15:0] sp;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [15:0] exp_sp_out;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] o_rd;
   logic [15:0] o_spo;
   logic        o_err;
   logic [7:0]  orig2, orig3;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'b00, 4'd2, 16'hF000, 16'h0010, 16'h0000, 32'h0,        32'h00001234, 16'h0000, 1'b0};
      vecs[1] = '{2'b10, 4'd4, 16'h0000, 16'h0000, 16'h0100, 32'hDEADBEEF, 32'h00000000, 16'h00FC, 1'b0};
      vecs[2] = '{2'b11, 4'd4, 16'h0000, 16'h0000, 16'h00FC, 32'h0,        32'hDEADBEEF, 16'h0100, 1'b0};
      vecs[3] = '{2'b01, 4'd2, 16'h1000, 16'hFFFF, 16'h0000, 32'h00005566, 32'h00000000, 16'h0000, 1'b0};
      vecs[4] = '{2'b00, 4'd2, 16'h1000, 16'hFFFF, 16'h0000, 32'h0,        32'h00005566, 16'h0000, 1'b0};
      vecs[5] = '{2'b01, 4'd0, 16'h2222, 16'h0040, 16'h0000, 32'hCAFEF00D, 32'h00000000, 16'h0000, 1'b1};
      vecs[6] = '{2'b00, 4'd5, 16'h3333, 16'h0000, 16'h0000, 32'h0,        32'h00000000, 16'h0000, 1'b1};

      reset = 1'b1; locked = 1'b1;
      mif.req = 1'b0; mif.op = 2'b00; mif.len = 4'd0; mif.seg = 16'h0;
      mif.off = 16'h0; mif.sp = 16'h0; mif.wdata = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", 64'(mif.busy), 64'd0);
      chk("rst_done", 64'(mif.done), 64'd0);
      chk("rst_err", 64'(mif.err), 64'd0);
      chk("rst_sp_we", 64'(mif.sp_we), 64'd0);
      chk("rst_wreq", 64'(mif.wreq), 64'd0);
      chk("rst_rdata", 64'(mif.rdata), 64'd0);
      chk("rst_sp_out", 64'(mif.sp_out), 64'd0);
      chk("rst_data", 64'(mif.data), 64'd0);
      chk("rst_address", 64'(mif.address), 64'd0);
      reset = 1'b0;

      for (int v = 0; v < 7; v++) begin
         run_txn(vecs[v].op, vecs[v].len, vecs[v].seg, vecs[v].off, vecs[v].sp, vecs[v].wdata,
                 o_rd, o_spo, o_err);
         chk($sformatf("vec%0d_rdata", v), 64'(o_rd), 64'(vecs[v].exp_rdata));
         chk($sformatf("vec%0d_err", v), 64'(o_err), 64'(vecs[v].exp_err));
         if (vecs[v].op[1] && !vecs[v].exp_err)
            chk($sformatf("vec%0d_sp_out", v), 64'(o_spo), 64'(vecs[v].exp_sp_out));
      end
      chk("push_mem_FC", 64'(mem_rd(20'h000FC)), 64'hEF);
      chk("push_mem_FF", 64'(mem_rd(20'h000FF)), 64'hDE);
      chk("wrap_mem_1FFFF", 64'(mem_rd(20'h1FFFF)), 64'h66);
      chk("wrap_mem_10000", 64'(mem_rd(20'h10000)), 64'h55);

      // req held while busy must not start a second transfer
      @(negedge clock);
      mif.req = 1'b1; mif.op = 2'b00; mif.len = 4'd3; mif.seg = 16'h4000; mif.off = 16'h0000;
      @(posedge clock);
      @(negedge clock);
      mif.op = 2'b01; mif.len = 4'd2;
      @(negedge clock);
      @(negedge clock);
      mif.req = 1'b0;
      @(negedge clock);
      chk("ign_done", 64'(mif.done), 64'd1);
      chk("ign_rdata", 64'(mif.rdata),
          64'({8'h00, ref_rd(20'h40002), ref_rd(20'h40001), ref_rd(20'h40000)}));
      @(negedge clock);
      chk("ign_busy1", 64'(mif.busy), 64'd0);
      @(negedge clock);
      chk("ign_busy2", 64'(mif.busy), 64'd0);
      chk("ign_wreq", 64'(mif.wreq), 64'd0);

      // locked low for three cycles in the middle of a WRITE
      @(negedge clock);
      mif.req = 1'b1; mif.op = 2'b01; mif.len = 4'd4; mif.seg = 16'h2000;
      mif.off = 16'h0040; mif.wdata = 32'hA1B2C3D4;
      @(posedge clock);
      @(negedge clock);
      mif.req = 1'b0;
      @(negedge clock);
      locked = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("stall_address", 64'(mif.address), 64'h20041);
         chk("stall_data", 64'(mif.data), 64'hC3);
         chk("stall_wreq", 64'(mif.wreq), 64'd1);
         chk("stall_busy", 64'(mif.busy), 64'd1);
      end
      locked = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (mif.done) begin
               seen = 1;
               break;
            end
         end
         chk("stall_done_seen", 64'(seen), 64'd1);
      end
      @(negedge clock);
      chk("stall_mem0", 64'(mem_rd(20'h20040)), 64'hD4);
      chk("stall_mem1", 64'(mem_rd(20'h20041)), 64'hC3);
      chk("stall_mem2", 64'(mem_rd(20'h20042)), 64'hB2);
      chk("stall_mem3", 64'(mem_rd(20'h20043)), 64'hA1);
      ref_mem[32'h20040] = 8'hD4; ref_mem[32'h20041] = 8'hC3;
      ref_mem[32'h20042] = 8'hB2; ref_mem[32'h20043] = 8'hA1;

      // reset in the middle of a WRITE aborts it
      orig2 = ref_rd(20'h30082);
      orig3 = ref_rd(20'h30083);
      @(negedge clock);
      mif.req = 1'b1; mif.op = 2'b01; mif.len = 4'd4; mif.seg = 16'h3000;
      mif.off = 16'h0080; mif.wdata = 32'h11223344;
      @(posedge clock);
      @(negedge clock);
      mif.req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("abort_wreq", 64'(mif.wreq), 64'd0);
      chk("abort_busy", 64'(mif.busy), 64'd0);
      chk("abort_address", 64'(mif.address), 64'd0);
      chk("abort_data", 64'(mif.data), 64'd0);
      chk("abort_rdata", 64'(mif.rdata), 64'd0);
      chk("abort_sp_out", 64'(mif.sp_out), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("abort_no_wreq", 64'(mif.wreq), 64'd0);
      end
      chk("abort_mem0", 64'(mem_rd(20'h30080)), 64'h44);
      chk("abort_mem1", 64'(mem_rd(20'h30081)), 64'h33);
      chk("abort_mem2", 64'(mem_rd(20'h30082)), 64'(orig2));
      chk("abort_mem3", 64'(mem_rd(20'h30083)), 64'(orig3));
      ref_mem[32'h30080] = 8'h44;
      ref_mem[32'h30081] = 8'h33;

      for (int n = 0; n < 40; n++) begin
         run_txn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 6)), 16'($urandom),
                 16'($urandom), 16'($urandom), $urandom, o_rd, o_spo, o_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter MAXB, default 4: maximum bytes per transfer, legal range 1..8.
REQ-002 Parameter OFFW, default 16: offset width; 16 gives real-mode wrap, 32 gives flat offsets.
REQ-003 Parameter ADDRW, default 20: physical address width.
REQ-004 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port locked, input, 1: clock enable; when low, all state and outputs hold.
REQ-007 Port req, input, 1: start request; sampled only in IDLE.
REQ-008 Port op, input, 2: operation select; 00 READ, 01 WRITE, 10 PUSH, 11 POP.
REQ-009 Port len, input, 4: byte count for the transfer.
REQ-010 Port seg, input, 16: segment value.
REQ-011 Port off, input, OFFW: offset for READ and WRITE.
REQ-012 Port sp, input, OFFW: stack pointer for PUSH and POP.
REQ-013 Port wdata, input, 8*MAXB: little-endian write data.
REQ-014 Port rdata, output, 8*MAXB: little-endian read result.
REQ-015 Port sp_out, output, OFFW: updated stack pointer.
REQ-016 Port sp_we, output, 1: one-cycle strobe marking sp_out valid.
REQ-017 Port busy, output, 1: high whenever the block is not in IDLE.
REQ-018 Port done, output, 1: one-cycle completion pulse.
REQ-019 Port err, output, 1: qualifies done; high for an illegal len.
REQ-020 Port address, output, ADDRW: external byte address.
REQ-021 Port bus, input, 8: read byte; it is combinational from address and sampled at the clock edge.
REQ-022 Port data, output, 8: write byte.
REQ-023 Port wreq, output, 1: write strobe; the byte is written at each edge where wreq=1.

Function
REQ-024 States SHALL be IDLE, XFER and FIN; every transition is gated by locked=1.
REQ-025 In IDLE with req=1, the block SHALL latch op, len, seg, wdata and the base offset, then enter XFER.
  - READ/WRITE base = off.
  - PUSH base = sp - len (mod 2^OFFW).
  - POP base = sp.
REQ-026 If len==0 or len>MAXB at acceptance, the block SHALL go directly to FIN with err=1 and perform no bus activity.
REQ-027 XFER SHALL run exactly len cycles; byte i (0..len-1) uses offset (base+i) mod 2^OFFW, and offset carries never propagate into the segment.
REQ-028 address SHALL equal ({seg,4'h0} + offset_i) truncated to ADDRW.
REQ-029 In IDLE and FIN, address SHALL be 0.
REQ-030 READ and POP SHALL capture bus into rdata byte i at the end of XFER cycle i.
REQ-031 rdata bytes at index len and above SHALL be zero.
REQ-032 rdata SHALL hold its value until the next accepted request.
REQ-033 WRITE and PUSH SHALL assert wreq=1 with data=wdata byte i throughout XFER cycle i.
REQ-034 wreq SHALL be 0 in every other state and cycle.
REQ-035 After the last XFER cycle the block SHALL enter FIN, where done=1 for one cycle.
  - err is valid in FIN.
  - PUSH/POP also assert sp_we=1 in FIN.
  - sp_out = base for PUSH; sp_out = sp + len for POP.
  - The block returns to IDLE on the next edge.
REQ-036 Latency SHALL be len+2 clock edges from the req-sampling edge to done going low.
REQ-037 A new request SHALL be accepted no earlier than the first IDLE cycle after FIN.
REQ-038 req while busy=1 SHALL be ignored (not queued).
REQ-039 When locked=0 mid-transfer, the byte index, address, data and wreq SHALL freeze.
  - A frozen wreq=1 is legal; the memory is likewise gated by locked.
REQ-040 Wrap: READ with off=16'hFFFF, len=2 SHALL access offsets FFFF then 0000 within the same segment.

Reset
REQ-041 On a clock edge with reset=1, the block SHALL enter IDLE regardless of locked or state, aborting any transfer.
REQ-042 After reset, busy, done, err, sp_we and wreq SHALL be 0.
REQ-043 After reset, rdata, sp_out, data and address SHALL be 0.
REQ-044 A write aborted by reset SHALL issue no further wreq cycles.

Verification
REQ-045 READ: seg=F000, off=0010, len=2, memory[F0010]=34, [F0011]=12 -> addresses F0010, F0011; rdata=00001234; done pulses 4 edges after req.
REQ-046 PUSH: seg=0000, sp=0100, len=4, wdata=DEADBEEF -> writes EF,BE,AD,DE to 000FC..000FF; sp_out=00FC with sp_we=1.
REQ-047 POP: sp=00FC on the REQ-046 memory, len=4 -> rdata=DEADBEEF; sp_out=0100.
REQ-048 Wrap: OFFW=16, seg=1000, off=FFFF, len=2, WRITE 5566 -> 66 written to 1FFFF, 55 written to 10000.
REQ-049 Error: len=0 and len=5 (MAXB=4) -> no wreq and no address change; done=1 and err=1 one edge after acceptance.
REQ-050 Stall and reset: locked low for 3 cycles mid-WRITE -> address/data/wreq frozen; then reset during XFER -> wreq=0 and busy=0 on the next edge.
